uart_tx_frame_gen: RTL
======================

// Module: uart_tx_frame_gen
// PURPOSE
// - Parametrised UART transmitter: start bit, DATA_WIDTH data bits (LSB first), optional parity, then 1 or 2 stop bits.
// - Serialiser, parity generator, bit-period counter and output select are all in this block.
// - Successor to the fixed 8-bit TX output-select path; adds runtime frame configuration and a valid/ready input handshake.
// - Sits between the system-side data source and the TX pin.
// PARAMETERS
// - DATA_WIDTH  8  data bits per frame, legal range 5..9
// - PRESC_W     6  width of PRESCALE; bit period = PRESCALE clocks
// PORTS
// - CLK         in   1           clock; one clock domain, all logic on rising edge
// - RST         in   1           synchronous, active-high reset
// - P_DATA      in   DATA_WIDTH  parallel data, sampled on accept
// - DATA_VALID  in   1           P_DATA valid
// - TX_READY    out  1           block can accept; transfer happens when DATA_VALID && TX_READY at a CLK edge
// - PAR_EN      in   1           parity bit present, sampled on accept
// - PAR_TYP     in   1           0 = even, 1 = odd, sampled on accept
// - STOP2       in   1           1 = two stop bits, sampled on accept
// - PRESCALE    in   PRESC_W     clocks per bit; value 0 is treated as 1; sampled on accept
// - TX_OUT      out  1           serial line, registered, idle high
// - Busy        out  1           frame in progress
// BEHAVIOUR
// - Reset values: TX_OUT = 1, Busy = 0, TX_READY = 0 during RST and 1 on the first cycle after RST deasserts.
// - Reset is synchronous and wins over everything. Reset mid-frame aborts the frame: next edge gives TX_OUT = 1, state IDLE, Busy = 0, hold register empty.
// - FSM states: IDLE -> START -> DATA -> (PARITY if PAR_EN) -> STOP -> IDLE.
// - Accept edge k: latch P_DATA, config and parity (even = ^P_DATA, odd = ~^P_DATA); move to START.
// - From edge k+1: TX_OUT = 0 and Busy = 1.
// - Every bit lasts exactly PRESCALE clocks. Bit counter counts 0..PRESCALE-1; the state/bit advances when the counter wraps.
// - DATA sends bit index 0..DATA_WIDTH-1. A data counter of clog2(DATA_WIDTH+1) bits wraps to 0 on exit.
// - STOP: TX_OUT = 1 for 1 or 2 bit periods per the latched STOP2.
// - Frame length = (2 + DATA_WIDTH + PAR_EN + STOP2) * PRESCALE clocks.
// - TX_OUT is driven from a registered select: 00 idle/stop = 1, 01 start = 0, 11 data bit, 10 parity.
// - Busy falls on the edge that ends the last stop bit, unless a held word starts (see CONFIGURATION).
// - Without hold: TX_READY = (state == IDLE). DATA_VALID while busy is ignored and the source must hold it.
// - Input changes during a frame (config or data) have no effect on the current frame.
// CONFIGURATION
// - Macro UART_TX_HOLD_EN.
// - Defined: adds a one-entry holding register (data + config). TX_READY = hold register empty, so one word can be accepted mid-frame.
//   - At the end of the last stop bit with hold full: go directly to START on the same edge. No idle cycle, Busy stays 1, hold empties, TX_READY rises.
//   - Accept while IDLE with hold empty bypasses the hold register (same latency as without the macro).
//   - Accept and end-of-frame on the same edge: the new word starts immediately, no gap.
// - Undefined: no holding register; behaviour as in BEHAVIOUR.
// STRUCTURE
// - Package uart_tx_pkg holds:
//   - typedef enum logic [2:0] tx_state_e {IDLE, START, DATA, PARITY, STOP}
//   - typedef logic [1:0] tx_sel_t with constants SEL_IDLE = 2'b00, SEL_START = 2'b01, SEL_DATA = 2'b11, SEL_PAR = 2'b10
//   - struct tx_cfg_t {par_en, par_typ, stop2, prescale}
// - One sub-module, uart_tx_baud_cnt: prescale counter with a bit_done pulse, cleared on state entry and on RST.
// - FSM, shift register, parity logic and output register live in the top module.
// TESTING
// - Check 1: DATA_WIDTH=8, PRESCALE=4, PAR_EN=1, PAR_TYP=0, P_DATA=8'hA5 -> TX_OUT = 0,1,0,1,0,0,1,0,1,0(par),1, each bit 4 clocks; Busy high 44 clocks.
// - Check 2: same data with PAR_TYP=1, STOP2=1 -> parity bit = 1, two stop bits, frame 48 clocks.
// - Check 3: PAR_EN=0, PRESCALE=0, P_DATA=8'h00 -> 1-clock bits: start, eight 0s, one stop; 10 clocks total.
// - Check 4: RST asserted mid-DATA (frame 0x3C) -> next edge TX_OUT=1, Busy=0, TX_READY=1 one cycle after RST drops; a new frame 0x81 is then correct.
// - Check 5: DATA_VALID held while Busy without UART_TX_HOLD_EN -> word is not taken until IDLE, and exactly one frame is sent per handshake.
// - Check 6: with UART_TX_HOLD_EN, 0x11 then 0x22 back-to-back -> second start bit follows the first stop bit with no idle cycle; Busy stays high across both frames.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// Shared types for the UART frame generator: FSM states, output-select
// codes and the per-frame configuration word latched on accept.
package uart_tx_pkg;

   // Wide enough for any PRESCALE port width this block is built with.
   localparam int PRESC_MAX_W = 16;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } tx_state_e;

   typedef logic [1:0] tx_sel_t;

   localparam tx_sel_t SEL_IDLE  = 2'b00;
   localparam tx_sel_t SEL_START = 2'b01;
   localparam tx_sel_t SEL_DATA  = 2'b11;
   localparam tx_sel_t SEL_PAR   = 2'b10;

   typedef struct packed {
      logic                   par_en;
      logic                   par_typ;
      logic                   stop2;
      logic [PRESC_MAX_W-1:0] prescale;
   } tx_cfg_t;

   // Line level for a given output select; idle and stop share the high level.
   function automatic logic sel_level(tx_sel_t sel, logic data_bit, logic par_bit);
      case (sel)
         SEL_START: return 1'b0;
         SEL_DATA:  return data_bit;
         SEL_PAR:   return par_bit;
         default:   return 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/uart_tx_baud_cnt.sv
// Bit-period counter: counts 0..prescale-1 and pulses bit_done on the last
// clock of each bit. Restarts from zero whenever the FSM enters a new state.
module uart_tx_baud_cnt
   import uart_tx_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   input  logic                   clr,
   input  logic [PRESC_MAX_W-1:0] prescale,
   output logic                   bit_done
);

   logic [PRESC_MAX_W-1:0] cnt_q;

   // prescale is never zero here; the top substitutes 1 when it latches config.
   assign bit_done = en && (cnt_q == (prescale - PRESC_MAX_W'(1)));

   // Count within a bit, wrapping at the terminal count.
   always_ff @(posedge clk) begin
      if (rst || clr || !en || bit_done) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + PRESC_MAX_W'(1);
      end
   end

endmodule

// File: rtl/uart_tx_frame_gen.sv
// UART transmitter with runtime frame configuration and valid/ready input.
// Optional build macro: UART_TX_HOLD_EN adds a one-word holding register so
// a word can be accepted mid-frame and sent with no idle gap.
//
// state  | meaning
// IDLE   | line high, waiting for a word
// START  | start bit (low) for one bit period
// DATA   | data bits LSB first, one bit period each
// PARITY | parity bit, only when the latched config enables it
// STOP   | one or two high stop bits, then IDLE or straight to START
module uart_tx_frame_gen
   import uart_tx_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int PRESC_W    = 6
)(
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [DATA_WIDTH-1:0] P_DATA,
   input  logic                  DATA_VALID,
   output logic                  TX_READY,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   input  logic                  STOP2,
   input  logic [PRESC_W-1:0]    PRESCALE,
   output logic                  TX_OUT,
   output logic                  Busy
);

   localparam int DCNT_W = $clog2(DATA_WIDTH + 1);

   tx_state_e             state_q, state_d;
   tx_sel_t               sel_d;
   tx_cfg_t               cfg_q, in_cfg, src_cfg;
   logic [DATA_WIDTH-1:0] shift_q, src_data;
   logic                  par_q;
   logic [DCNT_W-1:0]     dcnt_q;
   logic                  stop_q;
   logic                  tx_out_q, busy_q;
   logic                  bit_done, data_last, last_stop;
   logic                  accept, start_new, start_hold, load;

   // Incoming config; a zero prescale behaves as one clock per bit.
   always_comb begin
      in_cfg          = '0;
      in_cfg.par_en   = PAR_EN;
      in_cfg.par_typ  = PAR_TYP;
      in_cfg.stop2    = STOP2;
      in_cfg.prescale = (PRESCALE == '0) ? PRESC_MAX_W'(1) : PRESC_MAX_W'(PRESCALE);
   end

   assign accept    = DATA_VALID & TX_READY;
   assign data_last = (dcnt_q == DCNT_W'(DATA_WIDTH - 1));
   assign last_stop = (state_q == STOP) && bit_done && (!cfg_q.stop2 || stop_q);
   assign load      = start_new | start_hold;

`ifdef UART_TX_HOLD_EN
   logic                  hold_vld_q;
   logic [DATA_WIDTH-1:0] hold_data_q;
   tx_cfg_t               hold_cfg_q;

   assign TX_READY   = ~RST & ~hold_vld_q;
   // A word accepted while the line is free (or just freeing) skips the hold register.
   assign start_new  = accept & ((state_q == IDLE) | last_stop);
   assign start_hold = last_stop & hold_vld_q;
   assign src_data   = start_hold ? hold_data_q : P_DATA;
   assign src_cfg    = start_hold ? hold_cfg_q  : in_cfg;

   // Holding-register occupancy.
   always_ff @(posedge CLK) begin
      if (RST) begin
         hold_vld_q <= 1'b0;
      end else if (start_hold) begin
         hold_vld_q <= 1'b0;
      end else if (accept && !start_new) begin
         hold_vld_q <= 1'b1;
      end
   end

   // Holding-register payload.
   always_ff @(posedge CLK) begin
      if (accept && !start_new) begin
         hold_data_q <= P_DATA;
         hold_cfg_q  <= in_cfg;
      end
   end
`else
   assign TX_READY   = ~RST & (state_q == IDLE);
   assign start_new  = accept;
   assign start_hold = 1'b0;
   assign src_data   = P_DATA;
   assign src_cfg    = in_cfg;
`endif

   uart_tx_baud_cnt u_baud (
      .clk      (CLK),
      .rst      (RST),
      .en       (state_q != IDLE),
      .clr      (state_d != state_q),
      .prescale (cfg_q.prescale),
      .bit_done (bit_done)
   );

   // Next-state and output-select decode.
   always_comb begin
      state_d = state_q;
      sel_d   = SEL_IDLE;
      case (state_q)
         IDLE: begin
            if (load) state_d = START;
         end
         START: begin
            sel_d = SEL_START;
            if (bit_done) state_d = DATA;
         end
         DATA: begin
            sel_d = SEL_DATA;
            if (bit_done && data_last) state_d = cfg_q.par_en ? PARITY : STOP;
         end
         PARITY: begin
            sel_d = SEL_PAR;
            if (bit_done) state_d = STOP;
         end
         STOP: begin
            sel_d = SEL_IDLE;
            if (last_stop) state_d = load ? START : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State, line register, busy flag and bit/stop counters.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q  <= IDLE;
         tx_out_q <= 1'b1;
         busy_q   <= 1'b0;
         dcnt_q   <= '0;
         stop_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         tx_out_q <= sel_level(sel_d, shift_q[0], par_q ^ cfg_q.par_typ);
         busy_q   <= (state_q != IDLE);
         if (state_q == DATA && bit_done) begin
            dcnt_q <= data_last ? '0 : dcnt_q + DCNT_W'(1);
         end
         if (state_q == STOP && bit_done) begin
            stop_q <= ~last_stop;
         end
      end
   end

   // Frame payload: latched on start, shifted LSB first through the data bits.
   // par_q holds even parity; odd parity is applied at the output via par_typ.
   always_ff @(posedge CLK) begin
      if (load) begin
         shift_q <= src_data;
         cfg_q   <= src_cfg;
         par_q   <= ^src_data;
      end else if (state_q == DATA && bit_done) begin
         shift_q <= shift_q >> 1;
      end
   end

   assign TX_OUT = tx_out_q;
   assign Busy   = busy_q;

endmodule
